fp_addsub_pipe: RTL and testbench

//  Pipelined, parametrised IEEE-754 binary adder/subtractor with valid/ready handshake on both sides.

---
 rtl/fp_pkg.sv | 38 +++
 rtl/fp_lzc.sv | 18 +
 rtl/fp_addsub_pipe.sv | 234 +++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types, flag indices and helpers for the fp add/sub pipeline
package fp_pkg;

   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;
   localparam int FP_TAG_W = 4;

   localparam int FLG_INEXACT  = 0;
   localparam int FLG_OVERFLOW = 1;
   localparam int FLG_INVALID  = 2;

   typedef enum logic [2:0] {
      FP_ZERO,
      FP_SUB,
      FP_NORM,
      FP_INF,
      FP_NAN
   } fp_class_e;

   typedef struct packed {
      fp_class_e cls;
      logic      sign;
      logic      snan;
   } fp_info_t;

   function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                             input logic man_zero);
      if (exp_ones) return man_zero ? FP_INF : FP_NAN;
      if (exp_zero) return man_zero ? FP_ZERO : FP_SUB;
      return FP_NORM;
   endfunction

   // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
   function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
      return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter; all-zero input yields WIDTH
module fp_lzc #(
   parameter int WIDTH = 27,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] data_i,
   output logic [CW-1:0]    count_o
);

   // Ascending scan: the highest set bit is the last one to write the count.
   always_comb begin
      count_o = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (data_i[i]) count_o = CW'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fp_addsub_pipe.sv
// rtl/fp_addsub_pipe.sv - 4-stage IEEE-754 add/subtract with RNE rounding, flags and tag
module fp_addsub_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = FP_EXP_W,
   parameter int MAN_W = FP_MAN_W,
   parameter int TAG_W = FP_TAG_W
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [EXP_W+MAN_W:0]       in_a_i,
   input  logic [EXP_W+MAN_W:0]       in_b_i,
   input  logic                       in_op_i,
   input  logic [TAG_W-1:0]           in_tag_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [EXP_W+MAN_W:0]       out_res_o,
   output logic [TAG_W-1:0]           out_tag_o,
   output logic [2:0]                 out_flags_o
);

   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int EW  = EXP_W + 2;
   localparam int FW  = MAN_W + 4;
   localparam int AW  = MAN_W + 3;
   localparam int LZW = $clog2(FW + 1);

   localparam logic [W-1:0]          QNAN    = W'(fp_qnan(EXP_W, MAN_W));
   localparam logic signed [EW-1:0]  ONE     = $signed(EW'(1));
   localparam logic signed [EW-1:0]  EXP_MAX = $signed(EW'((1 << EXP_W) - 1));
   localparam logic [EXP_W-1:0]      SH_SAT  = EXP_W'(MAN_W + 3);

   typedef struct packed {
      logic                    byp;
      logic [W-1:0]            byp_res;
      logic [2:0]              byp_flags;
      logic                    sign;
      logic                    eff_sub;
      logic signed [EW-1:0]    exp;
      logic [TAG_W-1:0]        tag;
   } ctl_t;

   typedef struct packed {
      ctl_t                    ctl;
      logic [MAN_W:0]          man_l;
      logic [MAN_W:0]          man_s;
      logic [EXP_W-1:0]        diff;
   } s1_t;

   typedef struct packed {
      ctl_t                    ctl;
      logic [FW-1:0]           man_l;
      logic [FW-1:0]           man_s;
   } s2_t;

   typedef struct packed {
      ctl_t                    ctl;
      logic [FW:0]             sum;
   } s3_t;

   logic       [3:0] valid_q;
   s1_t              s1_d, s1_q;
   s2_t              s2_d, s2_q;
   s3_t              s3_d, s3_q;
   logic [W-1:0]     res_d, out_res_q;
   logic [2:0]       flags_d, out_flags_q;
   logic [TAG_W-1:0] out_tag_q;
   logic             advance;

   assign advance     = !valid_q[3] || out_ready_i;
   assign in_ready_o  = advance;
   assign out_valid_o = valid_q[3];
   assign out_res_o   = out_res_q;
   assign out_tag_o   = out_tag_q;
   assign out_flags_o = out_flags_q;

   // S1: classify, resolve specials, order operands by magnitude
   fp_info_t         a_info, b_info;
   logic [EXP_W-1:0] a_e, b_e, l_e, s_e, l_ee, s_ee;
   logic [MAN_W-1:0] a_m, b_m, l_m, s_m;
   logic             a_big;

   always_comb begin
      a_e         = in_a_i[W-2 -: EXP_W];
      b_e         = in_b_i[W-2 -: EXP_W];
      a_m         = in_a_i[MAN_W-1:0];
      b_m         = in_b_i[MAN_W-1:0];
      a_info.sign = in_a_i[W-1];
      b_info.sign = in_b_i[W-1] ^ in_op_i;
      a_info.cls  = fp_classify(a_e == '0, &a_e, a_m == '0);
      b_info.cls  = fp_classify(b_e == '0, &b_e, b_m == '0);
      a_info.snan = (a_info.cls == FP_NAN) && !a_m[MAN_W-1];
      b_info.snan = (b_info.cls == FP_NAN) && !b_m[MAN_W-1];

      a_big = in_a_i[W-2:0] >= in_b_i[W-2:0];
      l_e   = a_big ? a_e : b_e;
      s_e   = a_big ? b_e : a_e;
      l_m   = a_big ? a_m : b_m;
      s_m   = a_big ? b_m : a_m;
      l_ee  = (l_e == '0) ? EXP_W'(1) : l_e;
      s_ee  = (s_e == '0) ? EXP_W'(1) : s_e;

      s1_d             = '0;
      s1_d.ctl.tag     = in_tag_i;
      s1_d.ctl.sign    = a_big ? a_info.sign : b_info.sign;
      s1_d.ctl.eff_sub = a_info.sign ^ b_info.sign;
      s1_d.ctl.exp     = $signed(EW'(l_ee));
      s1_d.man_l       = {l_e != '0, l_m};
      s1_d.man_s       = {s_e != '0, s_m};
      s1_d.diff        = l_ee - s_ee;

      if (a_info.cls == FP_NAN || b_info.cls == FP_NAN) begin
         s1_d.ctl.byp                    = 1'b1;
         s1_d.ctl.byp_res                = QNAN;
         s1_d.ctl.byp_flags[FLG_INVALID] = a_info.snan | b_info.snan;
      end else if (a_info.cls == FP_INF && b_info.cls == FP_INF
                   && a_info.sign != b_info.sign) begin
         s1_d.ctl.byp                    = 1'b1;
         s1_d.ctl.byp_res                = QNAN;
         s1_d.ctl.byp_flags[FLG_INVALID] = 1'b1;
      end else if (a_info.cls == FP_INF) begin
         s1_d.ctl.byp     = 1'b1;
         s1_d.ctl.byp_res = {a_info.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (b_info.cls == FP_INF) begin
         s1_d.ctl.byp     = 1'b1;
         s1_d.ctl.byp_res = {b_info.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
   end

   // S2: align the smaller operand; everything shifted past R collapses into sticky
   logic [EXP_W-1:0] al_sh;
   logic [AW-1:0]    al_ext, al_shifted, al_lost;

   always_comb begin
      al_sh      = (s1_q.diff > SH_SAT) ? SH_SAT : s1_q.diff;
      al_ext     = {s1_q.man_s, 2'b00};
      al_shifted = al_ext >> al_sh;
      al_lost    = al_ext & ~({AW{1'b1}} << al_sh);
      s2_d.ctl   = s1_q.ctl;
      s2_d.man_l = {s1_q.man_l, 3'b000};
      s2_d.man_s = {al_shifted, |al_lost};
   end

   // S3: magnitude add/subtract; |L| >= |S| so the difference never goes negative
   always_comb begin
      s3_d.ctl = s2_q.ctl;
      if (s2_q.ctl.eff_sub) s3_d.sum = {1'b0, s2_q.man_l} - {1'b0, s2_q.man_s};
      else                  s3_d.sum = {1'b0, s2_q.man_l} + {1'b0, s2_q.man_s};
   end

   // S4: normalise, round to nearest even, pack
   logic [LZW-1:0]         lz;
   logic [FW:0]            sum;
   logic [FW-1:0]          norm;
   logic signed [EW-1:0]   lim, lz_e, sh_e, e_n, e_r;
   logic [MAN_W+1:0]       man_r;
   logic [MAN_W-1:0]       mant;
   logic                   up, inexact;

   fp_lzc #(
      .WIDTH (FW),
      .CW    (LZW)
   ) u_lzc (
      .data_i  (s3_q.sum[FW-1:0]),
      .count_o (lz)
   );

   always_comb begin
      sum  = s3_q.sum;
      lim  = s3_q.ctl.exp - ONE;
      lz_e = $signed(EW'(lz));
      sh_e = '0;
      if (sum[FW]) begin
         norm = {sum[FW:2], |sum[1:0]};
         e_n  = s3_q.ctl.exp + ONE;
      end else begin
         // Left shift stops at exponent 1 so that tiny results stay subnormal.
         sh_e = (lz_e > lim) ? lim : lz_e;
         norm = sum[FW-1:0] << sh_e;
         e_n  = s3_q.ctl.exp - sh_e;
      end

      up      = norm[2] & (norm[1] | norm[0] | norm[3]);
      inexact = |norm[2:0];
      man_r   = {1'b0, norm[FW-1:3]} + {{(MAN_W + 1){1'b0}}, up};
      if (man_r[MAN_W+1]) begin
         mant = man_r[MAN_W:1];
         e_r  = e_n + ONE;
      end else begin
         mant = man_r[MAN_W-1:0];
         e_r  = man_r[MAN_W] ? e_n : '0;
      end

      res_d                = {s3_q.ctl.sign, e_r[EXP_W-1:0], mant};
      flags_d              = '0;
      flags_d[FLG_INEXACT] = inexact;
      if (e_r >= EXP_MAX) begin
         res_d                 = {s3_q.ctl.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags_d[FLG_OVERFLOW] = 1'b1;
         flags_d[FLG_INEXACT]  = 1'b1;
      end
      if (sum == '0) begin
         res_d   = {s3_q.ctl.sign & !s3_q.ctl.eff_sub, {(W - 1){1'b0}}};
         flags_d = '0;
      end
      if (s3_q.ctl.byp) begin
         res_d   = s3_q.ctl.byp_res;
         flags_d = s3_q.ctl.byp_flags;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q     <= '0;
         s1_q        <= '0;
         s2_q        <= '0;
         s3_q        <= '0;
         out_res_q   <= '0;
         out_tag_q   <= '0;
         out_flags_q <= '0;
      end else if (advance) begin
         valid_q     <= {valid_q[2:0], in_valid_i};
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         s3_q        <= s3_d;
         out_res_q   <= res_d;
         out_tag_q   <= s3_q.ctl.tag;
         out_flags_q <= flags_d;
      end
   end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb/tb_fp_addsub_pipe.sv - scoreboard bench for fp_addsub_pipe with directed vectors
module tb_fp_addsub_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        in_op = 1'b0;
   logic [3:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_res;
   logic [3:0]  out_tag;
   logic [2:0]  out_flags;

   fp_addsub_pipe #(
      .EXP_W (8),
      .MAN_W (23),
      .TAG_W (4)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_a_i      (in_a),
      .in_b_i      (in_b),
      .in_op_i     (in_op),
      .in_tag_i    (in_tag),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_res_o   (out_res),
      .out_tag_o   (out_tag),
      .out_flags_o (out_flags)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  tag;
      logic [2:0]  flags;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_chk  = 0;
   int   n_pass = 0;

   localparam logic [31:0] ST_A   [8] = '{32'h40000000, 32'h40400000, 32'hBF800000, 32'h3F800000,
                                          32'h7F800000, 32'h40800000, 32'h3FC00000, 32'h00800000};
   localparam logic [31:0] ST_B   [8] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                                          32'h3F800000, 32'hC0000000, 32'h3FC00000, 32'h00000001};
   localparam logic        ST_OP  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam logic [31:0] ST_RES [8] = '{32'h40400000, 32'h40000000, 32'h00000000, 32'h00000000,
                                          32'h7F800000, 32'h40000000, 32'h40400000, 32'h007FFFFF};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic [3:0] tag, input logic [31:0] res, input logic [2:0] fl,
                       input bit lat);
      exp_t e;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_op    = op;
      in_tag   = tag;
      #1;
      for (int k = 0; k < 100 && !in_ready; k++) begin
         @(negedge clk);
         #1;
      end
      if (!in_ready) begin
         check("accept_timeout", in_ready, 1);
      end else begin
         e.res   = res;
         e.tag   = tag;
         e.flags = fl;
         e.acc   = cyc;
         e.lat   = lat;
         exp_q.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(negedge clk);
      if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
   endtask

   always @(negedge clk) begin
      #1;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", out_res, 32'hxxxxxxxx);
         end else begin
            mon_e = exp_q.pop_front();
            check("result", out_res, mon_e.res);
            check("tag", {28'd0, out_tag}, {28'd0, mon_e.tag});
            check("flags", {29'd0, out_flags}, {29'd0, mon_e.flags});
            if (mon_e.lat) check("latency", cyc - mon_e.acc, 4);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d results outstanding", exp_q.size());
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check("reset_out_valid", out_valid, 0);
      check("reset_out_res", out_res, 0);
      check("reset_out_tag", {28'd0, out_tag}, 0);
      check("reset_out_flags", {29'd0, out_flags}, 0);
      check("reset_in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      send(32'h3F800000, 32'h3F800000, 1'b0, 4'd1, 32'h40000000, 3'b000, 1'b1);
      drain();

      send(32'h3F800001, 32'h3F800000, 1'b1, 4'd2, 32'h34000000, 3'b000, 1'b0);
      send(32'h00000001, 32'h00000001, 1'b0, 4'd3, 32'h00000002, 3'b000, 1'b0);
      send(32'h3F800000, 32'h33800000, 1'b0, 4'd4, 32'h3F800000, 3'b001, 1'b0);
      send(32'h3F800001, 32'h33800000, 1'b0, 4'd5, 32'h3F800002, 3'b001, 1'b0);
      send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd6, 32'h7F800000, 3'b011, 1'b0);
      send(32'h80000000, 32'h80000000, 1'b0, 4'd7, 32'h80000000, 3'b000, 1'b0);
      send(32'h7F800000, 32'h7F800000, 1'b1, 4'd8, 32'h7FC00000, 3'b100, 1'b0);
      send(32'h7FC00000, 32'h3F800000, 1'b0, 4'd9, 32'h7FC00000, 3'b000, 1'b0);
      send(32'h7F800001, 32'h3F800000, 1'b0, 4'd10, 32'h7FC00000, 3'b100, 1'b0);
      send(32'h3F800000, 32'hFF800000, 1'b0, 4'd11, 32'hFF800000, 3'b000, 1'b0);
      drain();

      fork
         begin
            for (int i = 0; i < 8; i++)
               send(ST_A[i], ST_B[i], ST_OP[i], 4'(i), ST_RES[i], 3'b000, 1'b0);
         end
         begin
            repeat (6) @(negedge clk);
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               #1;
               check("stall_in_ready", in_ready, 0);
               check("stall_out_valid", out_valid, 1);
               @(negedge clk);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      send(32'h3F800000, 32'h3F800000, 1'b0, 4'd12, 32'h40000000, 3'b000, 1'b0);
      send(32'h3F800000, 32'h3F800000, 1'b0, 4'd13, 32'h40000000, 3'b000, 1'b0);
      send(32'h3F800000, 32'h3F800000, 1'b0, 4'd14, 32'h40000000, 3'b000, 1'b0);
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("midrst_out_valid_now", out_valid, 0);
      @(negedge clk);
      check("midrst_out_valid_edge", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      send(32'h40000000, 32'h40000000, 1'b0, 4'd9, 32'h40800000, 3'b000, 1'b1);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
